nway_gate_pipe: RTL

NWAY_GATE_PIPE -- requirements
Module: nway_gate_pipe

---
 rtl/gate_pkg.sv | 37 +++
 rtl/gate_stage.sv | 63 ++++++
 rtl/nway_gate_pipe.sv | 80 ++++++++
 3 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the N-way gate pipeline: operation encodings,
// operation classification helpers and the tree-depth function.
package gate_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;

    // 110 and 111 carry no operation; they travel through the tree as errors.
    function automatic logic op_illegal(input logic [2:0] op);
        return (op == 3'b110) || (op == 3'b111);
    endfunction

    // AND and NAND share an all-ones identity; every other family pads with zero.
    function automatic logic op_and_family(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_NAND);
    endfunction

    // Operations whose result is the inverse of the full reduction.
    function automatic logic op_inverted(input logic [2:0] op);
        return (op == OP_NAND) || (op == OP_NOR) || (op == OP_XNOR);
    endfunction

    // Ceiling log2, used as the number of tree levels.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_stage.sv
// One level of the reduction tree: combines adjacent operand pairs and
// registers the result together with the transaction's valid bit and OP.
// The last level also applies the final inversion for NAND/NOR/XNOR.
module gate_stage
    import gate_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int N_OUT = 1,
    parameter bit LAST  = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adv,
    input  logic                     in_valid,
    input  logic [2:0]               in_op,
    input  logic [2*N_OUT*WIDTH-1:0] in_data,
    output logic                     out_valid,
    output logic [2:0]               out_op,
    output logic [N_OUT*WIDTH-1:0]   out_data
);

    logic [N_OUT*WIDTH-1:0] data_next;

    generate
        for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pair
            logic [WIDTH-1:0] lhs;
            logic [WIDTH-1:0] rhs;
            logic [WIDTH-1:0] res;

            assign lhs = in_data[(2*gi)*WIDTH +: WIDTH];
            assign rhs = in_data[(2*gi+1)*WIDTH +: WIDTH];

            // Pairwise combine; illegal OPs collapse to zero so ERR results read 0.
            always_comb begin
                case (in_op)
                    OP_AND, OP_NAND: res = lhs & rhs;
                    OP_OR,  OP_NOR:  res = lhs | rhs;
                    OP_XOR, OP_XNOR: res = lhs ^ rhs;
                    default:         res = '0;
                endcase
                if (LAST && op_inverted(in_op)) begin
                    res = ~res;
                end
            end

            assign data_next[gi*WIDTH +: WIDTH] = res;
        end
    endgenerate

    // Level register; bubbles are stored as zero data/OP so nothing stale leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_op    <= '0;
            out_data  <= '0;
        end else if (adv) begin
            out_valid <= in_valid;
            out_op    <= in_valid ? in_op : 3'b000;
            out_data  <= in_valid ? data_next : '0;
        end
    end

endmodule

// File: rtl/nway_gate_pipe.sv
// Pipelined N-way bitwise gate: a balanced binary reduction tree with one
// register per level, a global stall (whole pipe freezes on backpressure)
// and an ERR flag for transactions carrying an illegal OP.
module nway_gate_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int NUM_IN = 2
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [NUM_IN*WIDTH-1:0] IN_DATA,
    input  logic [2:0]              OP,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [WIDTH-1:0]        OUT0,
    output logic                    ERR
);

    localparam int LAT    = clog2(NUM_IN);
    localparam int LEAVES = 1 << LAT;
    // All tree levels packed back to back: LEAVES + LEAVES/2 + ... + 1 nodes.
    localparam int BUS_W  = (2*LEAVES - 1) * WIDTH;

    logic [BUS_W-1:0]     data_bus;
    logic [LAT:0]         valid_bus;
    logic [LAT:0][2:0]    op_bus;
    logic [WIDTH-1:0]     pad_leaf;
    logic                 adv;

    // The pipe moves whenever the output slot is empty or being drained.
    assign adv       = !OUT_VALID | OUT_READY;
    assign IN_READY  = adv;

    assign valid_bus[0] = IN_VALID;
    assign op_bus[0]    = OP;
    assign pad_leaf     = op_and_family(OP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    generate
        // Leaves: real operands first, identity padding for the unused ones.
        for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < NUM_IN) begin : g_real
                assign data_bus[gi*WIDTH +: WIDTH] = IN_DATA[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign data_bus[gi*WIDTH +: WIDTH] = pad_leaf;
            end
        end

        // One registered tree level per iteration.
        for (genvar gi = 0; gi < LAT; gi++) begin : g_level
            localparam int N_IN_NODES  = LEAVES >> gi;
            localparam int N_OUT_NODES = LEAVES >> (gi + 1);
            localparam int OFF_IN      = (2*LEAVES - ((2*LEAVES) >> gi)) * WIDTH;
            localparam int OFF_OUT     = (2*LEAVES - ((2*LEAVES) >> (gi + 1))) * WIDTH;

            gate_stage #(
                .WIDTH (WIDTH),
                .N_OUT (N_OUT_NODES),
                .LAST  (gi == LAT - 1)
            ) u_stage (
                .clk       (CLK),
                .rst_n     (RSTn),
                .adv       (adv),
                .in_valid  (valid_bus[gi]),
                .in_op     (op_bus[gi]),
                .in_data   (data_bus[OFF_IN +: N_IN_NODES*WIDTH]),
                .out_valid (valid_bus[gi+1]),
                .out_op    (op_bus[gi+1]),
                .out_data  (data_bus[OFF_OUT +: N_OUT_NODES*WIDTH])
            );
        end
    endgenerate

    assign OUT_VALID = valid_bus[LAT];
    assign OUT0      = data_bus[BUS_W-WIDTH +: WIDTH];
    assign ERR       = valid_bus[LAT] & op_illegal(op_bus[LAT]);

endmodule
